ahblite_led_sequencer: RTL and testbench

//  AHB-Lite slave that drives the board LED bank from a programmable pattern table

---
 rtl/ahblite_led_sequencer_pkg.sv | 19 +
 rtl/ahblite_led_sequencer_timer.sv | 30 +++
 rtl/ahblite_led_sequencer.sv | 143 ++++++++++++++
 tb/tb_ahblite_led_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahblite_led_sequencer_pkg.sv
// Shared definitions for the AHB-Lite LED sequencer: word offsets of the
// register map (HADDR[5:2]), CTRL bit positions and FSM state encoding.
package ahblite_led_sequencer_pkg;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_PERIOD = 4'h1;
    localparam logic [3:0] A_LEN    = 4'h2;
    localparam logic [3:0] A_STATUS = 4'h3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/ahblite_led_sequencer_timer.sv
// Step-period timer: counts while enabled, wraps and pulses o_step at cnt==period.
// Ports: i_clk, i_rst_n, i_clr (sync clear), i_en, i_period -> o_step.
module ahblite_led_sequencer_timer #(
    parameter int W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_period,
    output logic         o_step
);

    logic [W-1:0] r_cnt;
    logic         w_hit;

    assign w_hit  = (r_cnt == i_period);
    assign o_step = i_en & w_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_hit ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/ahblite_led_sequencer.sv
// AHB-Lite slave stepping led_out through a programmable pattern table.
// Ports: AHB-Lite slave (HCLK..HRESP), led_out[7:0] LED drive, irq = STATUS.DONE.
module ahblite_led_sequencer
    import ahblite_led_sequencer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 24
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [7:0]  led_out,
    output logic        irq
);

    localparam int IW = $clog2(DEPTH);

    logic                w_aphase;
    logic                r_valid;
    logic                r_write;
    logic [3:0]          r_addr;
    logic                w_wr;
    logic                w_ctrl_wr;
    logic [IW-1:0]       w_pidx;
    logic [IW-1:0]       w_nidx;
    logic                w_step;
    logic                w_unused;

    logic                r_en;
    logic                r_oneshot;
    logic [PERIOD_W-1:0] r_period;
    logic [IW-1:0]       r_len;
    logic [7:0]          r_pat [DEPTH];
    logic [IW-1:0]       r_idx;
    logic                r_done;
    state_t              r_state;
    logic [7:0]          r_led;

    assign w_unused  = ^{HSIZE, HPROT, HTRANS[0], HADDR[31:6], HADDR[1:0]};
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign led_out   = r_led;
    assign irq       = r_done;

    // Zero-wait slave: every address phase is followed by its data phase.
    assign w_aphase  = HSEL & HTRANS[1] & HREADY;
    assign w_wr      = r_valid & r_write;
    assign w_ctrl_wr = w_wr & (r_addr == A_CTRL);
    assign w_pidx    = r_addr[IW-1:0];
    assign w_nidx    = r_idx + IW'(1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_valid <= w_aphase;
            r_write <= HWRITE;
            r_addr  <= HADDR[5:2];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_period <= '0;
            r_len    <= '0;
            for (int i = 0; i < DEPTH; i++) r_pat[i] <= '0;
        end else if (w_wr) begin
            if (r_addr == A_PERIOD) r_period <= HWDATA[PERIOD_W-1:0];
            if (r_addr == A_LEN)    r_len    <= HWDATA[IW-1:0];
            if (r_addr[3])          r_pat[w_pidx] <= HWDATA[7:0];
        end
    end

    ahblite_led_sequencer_timer #(
        .W (PERIOD_W)
    ) u_timer (
        .i_clk    (HCLK),
        .i_rst_n  (HRESETn),
        .i_clr    (w_ctrl_wr),
        .i_en     (r_state == S_RUN),
        .i_period (r_period),
        .o_step   (w_step)
    );

    // A CTRL write takes priority over a coincident step.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_en      <= 1'b0;
            r_oneshot <= 1'b0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_state   <= S_IDLE;
            r_led     <= 8'h00;
        end else if (w_ctrl_wr) begin
            r_en      <= HWDATA[CTRL_EN];
            r_oneshot <= HWDATA[CTRL_ONESHOT];
            r_done    <= 1'b0;
            if (HWDATA[CTRL_EN]) begin
                r_state <= S_RUN;
                r_idx   <= '0;
                r_led   <= r_pat[0];
            end else begin
                r_state <= S_IDLE;
                r_led   <= 8'h00;
            end
        end else if (r_state == S_RUN && w_step) begin
            if (r_idx != r_len) begin
                r_idx <= w_nidx;
                r_led <= r_pat[w_nidx];
            end else if (r_oneshot) begin
                r_state <= S_HOLD;
                r_done  <= 1'b1;
            end else begin
                r_idx <= '0;
                r_led <= r_pat[0];
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        case (r_addr)
            A_CTRL:   HRDATA[1:0]          = {r_oneshot, r_en};
            A_PERIOD: HRDATA[PERIOD_W-1:0] = r_period;
            A_LEN:    HRDATA[IW-1:0]       = r_len;
            A_STATUS: HRDATA[IW+1:0]       = {r_done, (r_state == S_RUN), r_idx};
            default:  if (r_addr[3]) HRDATA[7:0] = r_pat[w_pidx];
        endcase
    end

endmodule

// File: tb/tb_ahblite_led_sequencer.sv
// Scoreboard bench for ahblite_led_sequencer: stimulus pushes expected reads
// and LED/irq values from a step-count model; a monitor pops and compares.
module tb_ahblite_led_sequencer;

    localparam int DEPTH = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [3:0]  HPROT = 4'h3;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [7:0]  led_out;
    logic        irq;

    ahblite_led_sequencer #(.DEPTH(DEPTH), .PERIOD_W(24)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .led_out(led_out), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [7:0] led;
        logic       irq;
    } led_t;

    led_t        led_q[$];
    logic [31:0] rd_q[$];
    string       rd_nm[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start = 0;

    logic [7:0] s_pat [DEPTH];
    int s_period = 0;
    int s_len = 0;
    bit s_en = 0;
    bit s_one = 0;
    bit s_run = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Step k = j/(PERIOD+1); loop wraps k over LEN+1 entries, one-shot parks on LEN.
    function automatic led_t m_led(input int j);
        led_t r;
        int k;
        r.led = 8'h00;
        r.irq = 1'b0;
        if (s_run) begin
            k = j / (s_period + 1);
            if (s_one && k > s_len) begin
                r.led = s_pat[s_len];
                r.irq = 1'b1;
            end else begin
                r.led = s_pat[k % (s_len + 1)];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] m_status(input int j);
        int k;
        if (!s_run) return 32'h0;
        k = j / (s_period + 1);
        if (s_one && k > s_len) return {27'd0, 1'b1, 1'b0, 3'(s_len)};
        return {27'd0, 1'b0, 1'b1, 3'(k % (s_len + 1))};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input int j);
        if (a == 32'h00) return {30'd0, s_one, s_en};
        if (a == 32'h04) return 32'(s_period);
        if (a == 32'h08) return 32'(s_len);
        if (a == 32'h0C) return m_status(j);
        if (a >= 32'h20 && a < 32'h40) return {24'd0, s_pat[(a - 32'h20) >> 2]};
        return 32'h0;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
        if (a == 32'h00) begin
            s_en = d[0];
            s_one = d[1];
            s_run = d[0];
            start = cyc;
        end else if (a == 32'h04) begin
            s_period = int'(d[23:0]);
        end else if (a == 32'h08) begin
            s_len = int'(d[2:0]);
        end else if (a >= 32'h20 && a < 32'h40) begin
            s_pat[(a - 32'h20) >> 2] = d[7:0];
        end
    endtask

    task automatic rd(input logic [31:0] a, input string nm);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        rd_q.push_back(m_read(a, cyc + 1 - start));
        rd_nm.push_back(nm);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic push_run(input int n);
        for (int j = 0; j < n; j++) led_q.push_back(m_led(j));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (led_q.size() > 0 || rd_q.size() > 0) begin
            @(posedge HCLK);
            t++;
            if (t > 2000) begin
                n_chk++;
                n_fail++;
                $display("FAIL drain_timeout: %0d led and %0d read items left", led_q.size(), rd_q.size());
                led_q.delete();
                rd_q.delete();
                rd_nm.delete();
            end
        end
        #1;
    endtask

    logic dp_v = 1'b0;
    logic dp_w = 1'b0;

    always @(posedge HCLK) begin
        cyc  <= cyc + 1;
        dp_v <= HSEL & HTRANS[1] & HREADY;
        dp_w <= HWRITE;
    end

    always @(negedge HCLK) begin
        led_t e;
        if (dp_v) begin
            chk("hreadyout", 32'(HREADYOUT), 32'h1);
            chk("hresp", 32'(HRESP), 32'h0);
            if (!dp_w) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %h expected no read", HRDATA);
                end else begin
                    chk(rd_nm.pop_front(), HRDATA, rd_q.pop_front());
                end
            end
        end
        if (led_q.size() > 0) begin
            e = led_q.pop_front();
            chk("led_out", 32'(led_out), 32'(e.led));
            chk("irq", 32'(irq), 32'(e.irq));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        int          n;
        for (int i = 0; i < DEPTH; i++) s_pat[i] = 8'h00;

        #23 HRESETn = 1'b1;
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(32'h00, "rst_ctrl");
        rd(32'h04, "rst_period");
        rd(32'h08, "rst_len");
        rd(32'h0C, "rst_status");
        for (int i = 0; i < DEPTH; i++) rd(32'h20 + 4 * i, "rst_pat");
        drain();

        wr(32'h20, 32'h55);
        wr(32'h24, 32'hAA);
        wr(32'h28, 32'h0F);
        wr(32'h2C, 32'hF0);
        wr(32'h08, 32'h3);
        wr(32'h04, 32'h4);
        wr(32'h00, 32'h1);
        push_run(45);
        rd(32'h0C, "status_run");
        drain();

        wr(32'h00, 32'h1);
        push_run(10);
        repeat (7) @(posedge HCLK);
        wr(32'h00, 32'h1);
        push_run(8);
        rd(32'h0C, "status_restart");
        drain();

        wr(32'h00, 32'h3);
        push_run(30);
        drain();
        rd(32'h0C, "status_done");
        drain();
        chk("irq_hold", 32'(irq), 32'h1);
        wr(32'h00, 32'h0);
        push_run(2);
        rd(32'h00, "ctrl_off");
        drain();

        wr(32'h20, 32'h01);
        wr(32'h24, 32'h02);
        wr(32'h08, 32'h1);
        wr(32'h04, 32'h0);
        wr(32'h00, 32'h1);
        push_run(10);
        drain();

        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < DEPTH; i++) wr(32'h20 + 4 * i, $urandom);
            wr(32'h08, $urandom);
            wr(32'h04, $urandom_range(0, 3));
            wr(32'h00, {$urandom} & 32'hFFFF_FFFC | 32'h1 | (($urandom & 1) << 1));
            n = (s_len + 1) * (s_period + 1) * 2 + 3;
            push_run(n);
            rd(32'h0C, "status_rand");
            rd(32'h00, "ctrl_rand");
            rd(32'h20 + 4 * $urandom_range(0, DEPTH - 1), "pat_rand");
            drain();
            wr(32'h00, 32'h0);
            push_run(1);
            drain();
        end

        wr(32'h04, 32'hFFFF_FFFF);
        rd(32'h04, "period_max");
        wr(32'h08, 32'hFFFF_FFFF);
        rd(32'h08, "len_mask");
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, "unmapped_10");
        wr(32'h1C, 32'hCAFE_F00D);
        rd(32'h1C, "unmapped_1c");
        rd(32'h3C, "pat7_rb");
        drain();

        wr(32'h20, 32'h11);
        wr(32'h24, 32'h22);
        wr(32'h28, 32'h33);
        wr(32'h2C, 32'h44);
        wr(32'h08, 32'h3);
        wr(32'h04, 32'h2);
        wr(32'h00, 32'h1);
        repeat (4) @(posedge HCLK);
        #2;
        chk("led_pre_rst", 32'(led_out), 32'(m_led(cyc - start).led));
        #1 HRESETn = 1'b0;
        #1;
        chk("led_async_rst", 32'(led_out), 32'h0);
        chk("irq_async_rst", 32'(irq), 32'h0);
        for (int i = 0; i < DEPTH; i++) s_pat[i] = 8'h00;
        s_period = 0; s_len = 0; s_en = 0; s_one = 0; s_run = 0;
        #20 HRESETn = 1'b1;
        chk("led_after_rst", 32'(led_out), 32'h0);
        rd(32'h00, "ctrl_after_rst");
        rd(32'h04, "period_after_rst");
        rd(32'h08, "len_after_rst");
        rd(32'h20, "pat0_after_rst");
        drain();

        v1 = {24'd0, 8'($urandom)};
        v2 = {24'd0, 8'($urandom)} ^ 32'h5A;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h34;
        @(posedge HCLK); #1;
        HWDATA = v1; HWRITE = 1'b1; HADDR = 32'h34;
        @(posedge HCLK); #1;
        HWDATA = v2; HWRITE = 1'b0; HADDR = 32'h34;
        s_pat[5] = v2[7:0];
        rd_q.push_back(v2);
        rd_nm.push_back("pat5_b2b");
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        rd(32'h34, "pat5_rb");
        drain();
        chk("hreadyout_idle", 32'(HREADYOUT), 32'h1);
        chk("hresp_idle", 32'(HRESP), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
